// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative divider: operation codes, FSM states,
// default data width and small decode helpers.
package iter_divider_pkg;

  localparam int DATA_BUS = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_ITER = 2'b10,
    ST_FIX  = 2'b11
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] funct);
    logic sgn;
    case (funct)
      DIV_OP_DIV, DIV_OP_REM: sgn = 1'b1;
      default:                sgn = 1'b0;
    endcase
    return sgn;
  endfunction

  function automatic logic op_is_rem(input logic [1:0] funct);
    logic rem;
    case (funct)
      DIV_OP_REM, DIV_OP_REMU: rem = 1'b1;
      default:                 rem = 1'b0;
    endcase
    return rem;
  endfunction

endpackage

// File: rtl/iter_divider_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module lzc #(
  parameter int WIDTH = 32,
  parameter int OUT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] in_bits,
  output logic [OUT_W-1:0] count
);

  // Highest set bit is visited last, so it determines the count.
  always_comb begin
    count = OUT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      count = in_bits[i] ? OUT_W'(WIDTH - 1 - i) : count;
    end
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU/REM/REMU, RISC-V edge cases)
// with optional leading-zero alignment and start/busy/done/flush handshake.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH     = DATA_BUS,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       funct,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int LZW = $clog2(WIDTH) + 1;
  localparam int DW  = 2 * WIDTH - 1;
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES_VAL = {WIDTH{1'b1}};

  div_state_e       state_q, state_d;
  logic [1:0]       funct_q, funct_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [DW-1:0]    div_q, div_d;
  logic [LZW-1:0]   cnt_q, cnt_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, small_q, small_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d, busy_q, busy_d;

  logic             sgn, a_neg, b_neg, ge, special;
  logic [WIDTH-1:0] abs_a, abs_b, fix_quo, fix_rem;
  logic [LZW-1:0]   lz_a, lz_b, k_sel;

  assign sgn   = op_is_signed(funct_q);
  assign a_neg = sgn & a_q[WIDTH-1];
  assign b_neg = sgn & b_q[WIDTH-1];
  assign abs_a = a_neg ? -a_q : a_q;
  assign abs_b = b_neg ? -b_q : b_q;

  lzc #(.WIDTH(WIDTH)) u_lzc_a (.in_bits(abs_a), .count(lz_a));
  lzc #(.WIDTH(WIDTH)) u_lzc_b (.in_bits(abs_b), .count(lz_b));

  assign special = zero_d | ovf_d | small_d;
  assign k_sel   = EARLY_OUT ? (lz_b - lz_a) : LZW'(WIDTH - 1);
  assign ge      = ({{(WIDTH-1){1'b0}}, rem_q} >= div_q);

  // Sign correction and edge-case overrides applied in FIX.
  always_comb begin
    fix_quo = (a_neg ^ b_neg) ? -quo_q : quo_q;
    fix_rem = a_neg ? -rem_q : rem_q;
    if (zero_q) begin
      fix_quo = ONES_VAL;
      fix_rem = a_q;
    end else if (ovf_q) begin
      fix_quo = MIN_VAL;
      fix_rem = {WIDTH{1'b0}};
    end else if (small_q) begin
      fix_quo = {WIDTH{1'b0}};
      fix_rem = a_q;
    end else begin
      fix_quo = fix_quo;
      fix_rem = fix_rem;
    end
  end

  // Next-state and datapath update for the IDLE->PREP->ITER->FIX sequence.
  always_comb begin
    state_d  = state_q;
    funct_d  = funct_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    zero_d   = (b_q == {WIDTH{1'b0}});
    ovf_d    = sgn & (a_q == MIN_VAL) & (b_q == ONES_VAL);
    small_d  = (lz_a > lz_b);
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          funct_d = funct;
          a_d     = operand_1;
          b_d     = operand_2;
          state_d = ST_PREP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREP: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = abs_a;
          quo_d = {WIDTH{1'b0}};
          if (EARLY_OUT && special) begin
            state_d = ST_FIX;
          end else begin
            div_d   = DW'(abs_b) << k_sel;
            cnt_d   = k_sel;
            state_d = ST_ITER;
          end
        end
      end
      ST_ITER: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = ge ? (rem_q - div_q[WIDTH-1:0]) : rem_q;
          quo_d = {quo_q[WIDTH-2:0], ge};
          div_d = div_q >> 1;
          if (cnt_q == {LZW{1'b0}}) begin
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q - LZW'(1);
          end
        end
      end
      ST_FIX: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          result_d = op_is_rem(funct_q) ? fix_rem : fix_quo;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      funct_q  <= 2'b00;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      quo_q    <= {WIDTH{1'b0}};
      div_q    <= {DW{1'b0}};
      cnt_q    <= {LZW{1'b0}};
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      small_q  <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct_q  <= funct_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      zero_q   <= (state_q == ST_PREP) ? zero_d : zero_q;
      ovf_q    <= (state_q == ST_PREP) ? ovf_d : ovf_q;
      small_q  <= (state_q == ST_PREP) ? small_d : small_q;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
